// File: rtl/wide_add_sequencer.sv
// Wide adder that streams WIDTH-bit operands through an external 16-bit adder,
// one chunk per cycle, rippling the carry through a register between chunks.
module wide_add_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_cin,
  input  logic [15:0]      add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int CHUNKS = WIDTH / 16;
  localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CHUNKS-1:0][15:0] a_q, a_d;
  logic [CHUNKS-1:0][15:0] b_q, b_d;
  logic [CHUNKS-1:0][15:0] sum_q, sum_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
  logic                   valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  // The adder is only fed in RUN; its result chunk is written back on the same edge.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a        = a_q[idx_q];
        add_b        = b_q[idx_q];
        add_cin      = carry_q;
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (WIDTH=64) with a behavioural 16-bit adder
// closing the loop on the add_* ports.
module tb_wide_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;

  int compareCount;
  int mismatchCount;

  wide_add_sequencer #(.WIDTH(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout)
  );

  // Stand-in for the 16-bit carry-select adder: purely combinational.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Presents an operand set at a negedge in IDLE; returns at the negedge after the accept.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic c, input bit hold);
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    checkOutput("in_ready_before_accept", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    checkOutput("in_ready_in_run", {127'd0, in_ready}, 128'd0);
  endtask

  // Walks the RUN cycles checking the adder drive, then the latency and result.
  task automatic awaitResult(input logic [63:0] a, input logic [63:0] b, input logic c,
                             input logic [63:0] expSum, input logic expCout);
    logic [64:0] full;
    logic [63:0] aw;
    logic [63:0] bw;
    logic        expCarry;
    int          lat;
    full = {1'b0, a} + {1'b0, b} + {64'd0, c};
    aw   = a;
    bw   = b;
    lat  = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) begin
        expCarry = (lat == 0) ? c : (full[16*lat] ^ aw[16*lat] ^ bw[16*lat]);
        checkOutput("add_a_chunk", {112'd0, add_a}, {112'd0, aw[16*lat +: 16]});
        checkOutput("add_b_chunk", {112'd0, add_b}, {112'd0, bw[16*lat +: 16]});
        checkOutput("add_cin_chunk", {127'd0, add_cin}, {127'd0, expCarry});
      end
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 128'(lat), 128'd4);
    checkOutput("out_sum", {64'd0, out_sum}, {64'd0, expSum});
    checkOutput("out_cout", {127'd0, out_cout}, {127'd0, expCout});
    checkOutput("add_cin_done", {127'd0, add_cin}, 128'd0);
  endtask

  task automatic finishHandshake();
    @(negedge clk);
    checkOutput("out_valid_after_hs", {127'd0, out_valid}, 128'd0);
    checkOutput("in_ready_after_hs", {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    logic [63:0] heldSum;
    compareCount  = 0;
    mismatchCount = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("rst_out_sum", {64'd0, out_sum}, 128'd0);
    checkOutput("rst_out_cout", {127'd0, out_cout}, 128'd0);
    checkOutput("rst_add_a", {112'd0, add_a}, 128'd0);
    @(negedge clk);

    $display("[TB] test 1: small add");
    applyStimulus(64'h1F, 64'hC, 1'b0, 1'b0);
    awaitResult(64'h1F, 64'hC, 1'b0, 64'h2B, 1'b0);
    finishHandshake();

    $display("[TB] test 2: full carry ripple");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    awaitResult(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
    finishHandshake();

    $display("[TB] test 3: repeating pattern");
    applyStimulus(64'h9249_9249_9249_9249, 64'h9249_9249_9249_9249, 1'b1, 1'b0);
    awaitResult(64'h9249_9249_9249_9249, 64'h9249_9249_9249_9249, 1'b1,
                64'h2493_2493_2493_2493, 1'b1);
    finishHandshake();

    $display("[TB] test 4: backpressure");
    out_ready = 1'b0;
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
    awaitResult(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h2222_2222_2222_2211, 1'b0);
    heldSum  = 64'h2222_2222_2222_2211;
    in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    in_b     = 64'hFFFF_FFFF_FFFF_FFFF;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", {127'd0, out_valid}, 128'd1);
      checkOutput("stall_out_sum", {64'd0, out_sum}, {64'd0, heldSum});
      checkOutput("stall_out_cout", {127'd0, out_cout}, 128'd0);
      checkOutput("stall_in_ready", {127'd0, in_ready}, 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_out_valid_after_hs", {127'd0, out_valid}, 128'd0);
    checkOutput("bp_in_ready_after_hs", {127'd0, in_ready}, 128'd1);
    checkOutput("bp_sum_kept", {64'd0, out_sum}, {64'd0, heldSum});
    @(negedge clk);
    checkOutput("bp_still_idle", {127'd0, in_ready}, 128'd1);

    $display("[TB] test 5: reset mid-run");
    applyStimulus(64'h9249_9249_9249_9249, 64'h9249_9249_9249_9249, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("midrst_out_sum", {64'd0, out_sum}, 128'd0);
    checkOutput("midrst_out_cout", {127'd0, out_cout}, 128'd0);
    checkOutput("midrst_add_a", {112'd0, add_a}, 128'd0);
    applyStimulus(64'h1, 64'h1, 1'b0, 1'b0);
    awaitResult(64'h1, 64'h1, 1'b0, 64'h2, 1'b0);
    finishHandshake();

    $display("[TB] test 6: back-to-back with in_valid held");
    applyStimulus(64'hFFFF, 64'h1, 1'b0, 1'b1);
    awaitResult(64'hFFFF, 64'h1, 1'b0, 64'h1_0000, 1'b0);
    in_a   = 64'h5;
    in_b   = 64'h7;
    in_cin = 1'b1;
    @(negedge clk);
    checkOutput("b2b_out_valid_after_hs", {127'd0, out_valid}, 128'd0);
    checkOutput("b2b_in_ready_after_hs", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("b2b_second_accepted", {127'd0, in_ready}, 128'd0);
    awaitResult(64'h5, 64'h7, 1'b1, 64'hD, 1'b0);
    finishHandshake();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
